bridge_timer: RTL and testbench
===============================

BRIDGE_TIMER -- requirements
Module: bridge_timer

Interface
REQ-001 Parameter BASE, default 32'h0000_7F00: word-aligned base address of the 3-register window.
REQ-002 clk  input  1  single system clock; all state updates on rising edge.
REQ-003 reset  input  1  asynchronous, active-low reset.
REQ-004 Addr  input  32  bus address from the south-side bridge port; bits [1:0] ignored.
REQ-005 WD  input  32  bus write data.
REQ-006 WE  input  1  bus write enable; already qualified by the bridge (asserted only for non-DM addresses).
REQ-007 RD  output  32  bus read data, combinational from Addr.
REQ-008 IRQ  output  1  interrupt request to the CPU exception logic.

Function
REQ-009 Register map SHALL be: CTRL at BASE+0, PRESET at BASE+4, COUNT at BASE+8 (read-only); any other address SHALL be unmapped.
REQ-010 CTRL fields SHALL be: [0] EN, [2:1] MODE (00 one-shot, 01 auto-reload, 1x treated as 00), [3] IM; CTRL[31:4] SHALL read 0 and ignore writes.
REQ-011 A write (WE=1) to CTRL or PRESET SHALL take effect at the next rising edge; writes to COUNT or unmapped addresses SHALL be ignored.
REQ-012 RD SHALL return the addressed register in the same cycle; unmapped addresses SHALL read 32'h0.
REQ-013 FSM states SHALL be IDLE, LOAD, CNT, INT.
REQ-014 IDLE: EN=1 -> LOAD; else stay.
REQ-015 LOAD: COUNT <= PRESET, -> CNT (1 cycle).
REQ-016 CNT: EN=0 -> IDLE with COUNT frozen; COUNT>1 -> decrement; COUNT==1 -> COUNT<=0, -> INT; COUNT==0 (PRESET was 0) -> INT without decrement.
REQ-017 INT, MODE 00: set sticky irq_flag, clear CTRL.EN, -> IDLE.
REQ-018 INT, MODE 01: assert irq_flag for exactly this one cycle, -> LOAD.
REQ-019 IRQ SHALL equal CTRL.IM AND irq_flag (registered flag, no combinational path from bus inputs).
REQ-020 Sticky irq_flag (MODE 00) SHALL clear on the edge of any write to CTRL or PRESET.
REQ-021 Latency: write EN=1 at edge N -> LOAD in N+1 -> first decrement at N+2; PRESET=P (P>=1) -> INT entered P+1 cycles after LOAD -> irq_flag visible the following cycle.
REQ-022 Simultaneous bus write to CTRL and hardware EN clear in INT: bus write SHALL win.
REQ-023 PRESET write during CNT SHALL NOT affect COUNT until the next LOAD.
REQ-024 COUNT arithmetic SHALL be 32-bit unsigned; no wrap below 0.

Reset
REQ-025 On reset low, asynchronously: CTRL=0, PRESET=0, COUNT=0, irq_flag=0, state=IDLE; IRQ=0 and RD reflects zeros.
REQ-026 Reset asserted mid-count SHALL abort immediately; no IRQ after release until reprogrammed.

Structure
REQ-027 Register offsets, CTRL bit positions, MODE codes and state encodings SHALL live in the shared define header beside DMmin/DMmax; default BASE SHALL be defined there.
REQ-028 Single flat module, no sub-modules.

Verification
REQ-029 PRESET=5, CTRL=0x9 (EN,IM,mode 0) -> COUNT 5,4,3,2,1,0; IRQ=1 held; CTRL reads 0x8; write CTRL=0x8 -> IRQ=0 next cycle.
REQ-030 PRESET=3, CTRL=0xB (auto-reload) -> IRQ one-cycle pulse every 5 cycles, COUNT reloads to 3 each period.
REQ-031 PRESET=0, CTRL=0x1 -> INT reached 2 cycles after LOAD; IM=0 so IRQ stays 0, irq_flag set internally; later CTRL=0x8 write clears flag (IRQ stays 0).
REQ-032 Mid-count CTRL=0x0 at COUNT=7 -> COUNT holds 7; CTRL=0x1 -> reload from PRESET; write to COUNT (0xFFFF) -> ignored; read BASE+12 -> 0.
REQ-033 Assert reset during CNT with COUNT=2 -> all registers 0, IRQ never asserts after release.

Source files
------------

// File: rtl/bridge_timer_pkg.sv
// Shared definitions for the bridge timer: data-memory bounds, register window
// layout, CTRL bit positions, MODE codes and FSM state encoding.
package bridge_timer_pkg;

   localparam logic [31:0] DM_MIN       = 32'h0000_0000;
   localparam logic [31:0] DM_MAX       = 32'h0000_2FFF;
   localparam logic [31:0] DEFAULT_BASE = 32'h0000_7F00;

   localparam logic [31:0] OFF_CTRL   = 32'h0;
   localparam logic [31:0] OFF_PRESET = 32'h4;
   localparam logic [31:0] OFF_COUNT  = 32'h8;

   localparam int CTRL_EN_BIT   = 0;
   localparam int CTRL_MODE_LSB = 1;
   localparam int CTRL_IM_BIT   = 3;

   localparam logic [1:0] MODE_ONESHOT = 2'b00;
   localparam logic [1:0] MODE_AUTO    = 2'b01;

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      LOAD = 2'b01,
      CNT  = 2'b10,
      INT  = 2'b11
   } timer_state_e;

   // The bridge uses this to keep timer writes away from data memory.
   function automatic logic in_dm(input logic [31:0] addr);
      return (addr >= DM_MIN) && (addr <= DM_MAX);
   endfunction

endpackage

// File: rtl/bridge_timer.sv
// Memory-mapped down-counter on the south-side bridge: CTRL/PRESET/COUNT window,
// one-shot or auto-reload operation, maskable interrupt request.
module bridge_timer
   import bridge_timer_pkg::*;
#(
   parameter logic [31:0] BASE = DEFAULT_BASE
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] Addr,
   input  logic [31:0] WD,
   input  logic        WE,
   output logic [31:0] RD,
   output logic        IRQ
);

   localparam logic [31:0] ADDR_CTRL   = BASE + OFF_CTRL;
   localparam logic [31:0] ADDR_PRESET = BASE + OFF_PRESET;
   localparam logic [31:0] ADDR_COUNT  = BASE + OFF_COUNT;

   timer_state_e state, state_next;
   logic        ctrl_en;
   logic [1:0]  ctrl_mode;
   logic        ctrl_im;
   logic [31:0] preset;
   logic [31:0] count, count_next;
   logic        irq_flag;
   logic        irq_pulse;
   logic        clear_en;
   logic        irq_set;
   logic        sel_ctrl, sel_preset, sel_count;
   logic        wr_ctrl, wr_preset;
   logic        unused_addr_bits;

   assign unused_addr_bits = &{1'b0, Addr[1:0]};

   assign sel_ctrl   = (Addr[31:2] == ADDR_CTRL[31:2]);
   assign sel_preset = (Addr[31:2] == ADDR_PRESET[31:2]);
   assign sel_count  = (Addr[31:2] == ADDR_COUNT[31:2]);
   assign wr_ctrl    = WE & sel_ctrl;
   assign wr_preset  = WE & sel_preset;

   always_comb begin
      state_next = state;
      count_next = count;
      clear_en   = 1'b0;
      irq_set    = 1'b0;
      case (state)
         IDLE: if (ctrl_en) state_next = LOAD;
         LOAD: begin
            count_next = preset;
            state_next = CNT;
         end
         CNT: begin
            if (!ctrl_en) begin
               state_next = IDLE;
            end else if (count > 32'd1) begin
               count_next = count - 32'd1;
            end else begin
               // Covers both the final step from 1 and a zero PRESET.
               count_next = '0;
               state_next = INT;
            end
         end
         INT: begin
            irq_set = 1'b1;
            if (ctrl_mode == MODE_AUTO) begin
               state_next = LOAD;
            end else begin
               clear_en   = 1'b1;
               state_next = IDLE;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state <= IDLE;
         count <= '0;
      end else begin
         state <= state_next;
         count <= count_next;
      end
   end

   // Bus writes to CTRL take priority over the one-shot EN clear.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         ctrl_en   <= 1'b0;
         ctrl_mode <= MODE_ONESHOT;
         ctrl_im   <= 1'b0;
         preset    <= '0;
         irq_flag  <= 1'b0;
         irq_pulse <= 1'b0;
      end else begin
         if (wr_ctrl) begin
            ctrl_en   <= WD[CTRL_EN_BIT];
            ctrl_mode <= WD[CTRL_MODE_LSB +: 2];
            ctrl_im   <= WD[CTRL_IM_BIT];
         end else if (clear_en) begin
            ctrl_en <= 1'b0;
         end
         if (wr_preset) preset <= WD;
         if (irq_set) irq_flag <= 1'b1;
         else if (wr_ctrl || wr_preset || irq_pulse) irq_flag <= 1'b0;
         irq_pulse <= irq_set && (ctrl_mode == MODE_AUTO);
      end
   end

   always_comb begin
      RD = '0;
      if (sel_ctrl) RD = {28'h0, ctrl_im, ctrl_mode, ctrl_en};
      else if (sel_preset) RD = preset;
      else if (sel_count) RD = count;
   end

   assign IRQ = ctrl_im & irq_flag;

endmodule

// File: tb/tb_bridge_timer.sv
// Randomized bench for bridge_timer, scored against a timeline model in which
// the countdown position is tracked as an offset from the most recent reload.
module tb_bridge_timer;

   localparam logic [31:0] BASE     = 32'h0000_7F00;
   localparam logic [31:0] A_CTRL   = BASE;
   localparam logic [31:0] A_PRESET = BASE + 32'd4;
   localparam logic [31:0] A_COUNT  = BASE + 32'd8;
   localparam logic [31:0] A_HOLE   = BASE + 32'd12;

   logic        clk = 1'b0;
   logic        reset;
   logic [31:0] Addr, WD, RD;
   logic        WE, IRQ;

   bridge_timer #(.BASE(BASE)) dut (
      .clk(clk), .reset(reset), .Addr(Addr), .WD(WD), .WE(WE), .RD(RD), .IRQ(IRQ)
   );

   always #5 clk = ~clk;

   int vectors = 0;
   int miscompares = 0;

   // Reference model: programmer-visible registers plus a timeline position.
   // m_t = -1 when stopped, 0 in the reload cycle, k>=1 = k cycles after reload.
   bit          m_en, m_im, m_flag, m_pulse;
   bit   [1:0]  m_mode;
   logic [31:0] m_preset, m_count, m_p;
   int          m_t;

   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      vectors++;
      if (observed !== expected) begin
         miscompares++;
         $display("[TB] FAIL %s: got %h, expected %h at %0t", tag, observed, expected, $time);
      end
   endtask

   function automatic bit hits(input logic [31:0] a, input logic [31:0] reg_addr);
      return a[31:2] == reg_addr[31:2];
   endfunction

   function automatic logic [31:0] modelRead(input logic [31:0] a);
      if (hits(a, A_CTRL)) return {28'h0, m_im, m_mode, m_en};
      if (hits(a, A_PRESET)) return m_preset;
      if (hits(a, A_COUNT)) return m_count;
      return 32'h0;
   endfunction

   function automatic void modelReset();
      m_en = 0; m_im = 0; m_mode = 0; m_flag = 0; m_pulse = 0;
      m_preset = 0; m_count = 0; m_p = 0; m_t = -1;
   endfunction

   // Interrupt fires at offset max(P,1)+1 after reload; count at offset k is P-k+1 floored at 0.
   function automatic void modelStep(input bit wr_ctrl, input bit wr_preset, input logic [31:0] d);
      bit fire = 0;
      bit clr_en = 0;
      bit auto_mode = (m_mode == 2'b01);
      int fire_at = ((m_p == 0) ? 1 : int'(m_p)) + 1;
      if (m_t == -1) begin
         if (m_en) m_t = 0;
      end else if (m_t == 0) begin
         m_p = m_preset;
         m_count = m_preset;
         m_t = 1;
      end else if (m_t < fire_at) begin
         if (!m_en) m_t = -1;
         else begin
            m_count = (m_p > 32'(m_t)) ? m_p - 32'(m_t) : 32'h0;
            m_t++;
         end
      end else begin
         fire = 1;
         if (auto_mode) m_t = 0;
         else begin
            clr_en = 1;
            m_t = -1;
         end
      end
      if (fire) m_flag = 1;
      else if (wr_ctrl || wr_preset || m_pulse) m_flag = 0;
      m_pulse = fire && auto_mode;
      if (wr_ctrl) {m_im, m_mode, m_en} = d[3:0];
      else if (clr_en) m_en = 0;
      if (wr_preset) m_preset = d;
   endfunction

   task automatic applyStimulus(input logic [31:0] a, input logic we, input logic [31:0] d,
                                input string tag);
      @(negedge clk);
      Addr = a; WE = we; WD = d;
      #1;
      checkOutput({tag, "_rd"}, RD, modelRead(a));
      checkOutput({tag, "_irq"}, {31'h0, IRQ}, {31'h0, m_flag & m_im});
      @(posedge clk);
      modelStep(we && hits(a, A_CTRL), we && hits(a, A_PRESET), d);
   endtask

   task automatic checkAllZero(input string tag);
      Addr = A_CTRL;   #1; checkOutput({tag, "_ctrl"}, RD, 32'h0);
      Addr = A_PRESET; #1; checkOutput({tag, "_preset"}, RD, 32'h0);
      Addr = A_COUNT;  #1; checkOutput({tag, "_count"}, RD, 32'h0);
      checkOutput({tag, "_irq"}, {31'h0, IRQ}, 32'h0);
   endtask

   task automatic midCycleReset();
      @(negedge clk);
      WE = 0;
      #1 reset = 0;
      modelReset();
      checkAllZero("async_rst");
      @(negedge clk);
      reset = 1;
      @(posedge clk);
      modelStep(0, 0, 32'h0);
   endtask

   task automatic runReads(input int n, input string tag);
      for (int i = 0; i < n; i++) applyStimulus(A_COUNT, 0, 32'h0, tag);
   endtask

   initial begin
      reset = 0; Addr = 0; WE = 0; WD = 0;
      modelReset();
      #12;
      checkAllZero("por");
      @(negedge clk);
      reset = 1;
      @(posedge clk);
      modelStep(0, 0, 32'h0);

      // One-shot with sticky IRQ, EN self-clears, CTRL write clears the flag.
      applyStimulus(A_PRESET, 1, 32'd5, "os_wp");
      applyStimulus(A_CTRL, 1, 32'h9, "os_wc");
      runReads(12, "os_cnt");
      @(negedge clk);
      Addr = A_CTRL; WE = 0; #1;
      checkOutput("os_ctrl_done", RD, 32'h8);
      checkOutput("os_irq_sticky", {31'h0, IRQ}, 32'h1);
      @(posedge clk);
      modelStep(0, 0, 32'h0);
      applyStimulus(A_CTRL, 1, 32'h8, "os_clr");
      runReads(3, "os_after");

      // Auto-reload with a periodic one-cycle pulse, then stop.
      applyStimulus(A_PRESET, 1, 32'd3, "ar_wp");
      applyStimulus(A_CTRL, 1, 32'hB, "ar_wc");
      runReads(22, "ar_cnt");
      applyStimulus(A_CTRL, 1, 32'h0, "ar_stop");
      runReads(4, "ar_idle");

      // Zero preset, masked interrupt.
      applyStimulus(A_PRESET, 1, 32'd0, "z_wp");
      applyStimulus(A_CTRL, 1, 32'h1, "z_wc");
      runReads(6, "z_cnt");
      applyStimulus(A_CTRL, 1, 32'h8, "z_clr");
      runReads(2, "z_after");

      // Pause at 7, ignored COUNT write, unmapped read, resume from PRESET.
      applyStimulus(A_PRESET, 1, 32'd9, "p_wp");
      applyStimulus(A_CTRL, 1, 32'h1, "p_wc");
      for (int i = 0; i < 30 && m_count != 32'd7; i++) applyStimulus(A_COUNT, 0, 0, "p_run");
      applyStimulus(A_CTRL, 1, 32'h0, "p_pause");
      runReads(3, "p_hold");
      applyStimulus(A_COUNT, 1, 32'hFFFF, "p_wcount");
      applyStimulus(A_HOLE, 0, 32'h0, "p_hole");
      applyStimulus(A_PRESET, 1, 32'd4, "p_wp2");
      applyStimulus(A_CTRL, 1, 32'h9, "p_resume");
      runReads(12, "p_reload");

      // Reset asserted mid-count, no interrupt afterwards.
      applyStimulus(A_PRESET, 1, 32'd5, "r_wp");
      applyStimulus(A_CTRL, 1, 32'h9, "r_wc");
      for (int i = 0; i < 30 && !(m_t > 0 && m_count == 32'd2); i++)
         applyStimulus(A_COUNT, 0, 0, "r_run");
      midCycleReset();
      runReads(20, "r_after");

      // Randomized bus traffic.
      for (int i = 0; i < 2500; i++) begin
         int r = $urandom_range(0, 99);
         logic [31:0] d = $urandom;
         logic [31:0] lo = {30'h0, 2'($urandom_range(0, 3))};
         if (r < 60) begin
            case ($urandom_range(0, 3))
               0: applyStimulus(A_CTRL | lo, 0, d, "rnd_rd");
               1: applyStimulus(A_PRESET | lo, 0, d, "rnd_rd");
               2: applyStimulus(A_COUNT | lo, 0, d, "rnd_rd");
               default: applyStimulus(A_HOLE | lo, 0, d, "rnd_rd");
            endcase
         end else if (r < 75) begin
            d[0] = ($urandom_range(0, 9) < 7);
            applyStimulus(A_CTRL | lo, 1, d, "rnd_wc");
         end else if (r < 88) begin
            applyStimulus(A_PRESET | lo, 1, 32'($urandom_range(0, 9)), "rnd_wp");
         end else if (r < 94) begin
            applyStimulus(A_COUNT | lo, 1, d, "rnd_wcount");
         end else begin
            applyStimulus($urandom, 1, d, "rnd_wx");
         end
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
